// File: rtl/midi_pkg.sv
// Shared MIDI definitions: status nibbles, real-time threshold, baud rate and
// the state/event types used by the MIDI receive path.
package midi_pkg;

   localparam logic [3:0] NOTE_OFF     = 4'h8;
   localparam logic [3:0] NOTE_ON      = 4'h9;
   localparam logic [7:0] REALTIME_MIN = 8'hF8;
   localparam int         MIDI_BAUD    = 31250;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   typedef enum logic [1:0] {
      WAIT_STATUS,
      WAIT_DATA1,
      WAIT_DATA2
   } parser_state_t;

   typedef struct packed {
      logic       note_on;
      logic [6:0] note;
      logic [6:0] velocity;
      logic [3:0] channel;
   } note_event_t;

   // Only note-on and note-off open a message this receiver cares about.
   function automatic logic is_note_status(input logic [7:0] b);
      return (b[7:4] == NOTE_OFF) || (b[7:4] == NOTE_ON);
   endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART byte receiver with a 2-flop input synchronizer and mid-bit sampling.
module uart_rx
   import midi_pkg::*;
#(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = MIDI_BAUD
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic       byte_valid,
   output logic [7:0] data,
   output logic       framing_error
);

   localparam int BIT_PERIOD  = CLK_FREQ / BAUD;
   localparam int HALF_PERIOD = BIT_PERIOD / 2;
   localparam int CNT_W       = $clog2(BIT_PERIOD + 1);

   logic rx_meta, rx_sync, rx_prev;

   rx_state_t        state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [2:0]       bit_idx, bit_idx_next;
   logic [7:0]       shift, shift_next;
   logic             byte_valid_next, framing_error_next;

   // NOTE: the synchronizer resets to 1 so a released reset looks like an idle
   // line and cannot fake a start edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   // NOTE: every state element uses <= so all flops update from the same
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= RX_IDLE;
         cnt           <= '0;
         bit_idx       <= '0;
         shift         <= '0;
         byte_valid    <= 1'b0;
         framing_error <= 1'b0;
      end else begin
         state         <= state_next;
         cnt           <= cnt_next;
         bit_idx       <= bit_idx_next;
         shift         <= shift_next;
         byte_valid    <= byte_valid_next;
         framing_error <= framing_error_next;
      end
   end

   // NOTE: defaults first, so no path through the case leaves a variable
   // unassigned and infers a latch.
   always_comb begin
      state_next         = state;
      cnt_next           = cnt;
      bit_idx_next       = bit_idx;
      shift_next         = shift;
      byte_valid_next    = 1'b0;
      framing_error_next = 1'b0;

      case (state)
         RX_IDLE: begin
            if (rx_prev && !rx_sync) begin
               state_next = RX_START;
               cnt_next   = CNT_W'(HALF_PERIOD - 1);
            end
         end

         RX_START: begin
            if (cnt == '0) begin
               // A start bit that is high again at mid-bit was only a glitch.
               if (rx_sync) begin
                  state_next = RX_IDLE;
               end else begin
                  state_next   = RX_DATA;
                  cnt_next     = CNT_W'(BIT_PERIOD - 1);
                  bit_idx_next = '0;
               end
            end else begin
               cnt_next = cnt - 1'b1;
            end
         end

         RX_DATA: begin
            if (cnt == '0) begin
               shift_next = {rx_sync, shift[7:1]};
               cnt_next   = CNT_W'(BIT_PERIOD - 1);
               if (bit_idx == 3'd7) begin
                  state_next = RX_STOP;
               end else begin
                  bit_idx_next = bit_idx + 3'd1;
               end
            end else begin
               cnt_next = cnt - 1'b1;
            end
         end

         RX_STOP: begin
            if (cnt == '0) begin
               state_next         = RX_IDLE;
               byte_valid_next    = rx_sync;
               framing_error_next = !rx_sync;
            end else begin
               cnt_next = cnt - 1'b1;
            end
         end

         default: state_next = RX_IDLE;
      endcase
   end

   assign data = shift;

endmodule

// File: rtl/midi_note_receiver.sv
// MIDI note-on/note-off receiver: UART byte stream into a running-status parser.
module midi_note_receiver
   import midi_pkg::*;
#(
   parameter int         CLK_FREQ     = 100_000_000,
   parameter int         BAUD         = MIDI_BAUD,
   parameter logic [3:0] MIDI_CHANNEL = 4'd0,
   parameter logic       OMNI         = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic       note_valid,
   output logic       note_on,
   output logic [6:0] note,
   output logic [6:0] velocity,
   output logic [3:0] channel,
   output logic       framing_error
);

   logic       byte_valid;
   logic [7:0] rx_byte;
   logic       rx_framing_error;

   uart_rx #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD)
   ) u_uart (
      .clk           (clk),
      .reset         (reset),
      .rx            (rx),
      .byte_valid    (byte_valid),
      .data          (rx_byte),
      .framing_error (rx_framing_error)
   );

   parser_state_t pstate, pstate_next;
   logic [7:0]    status, status_next;
   logic          status_valid, status_valid_next;
   logic [6:0]    data1, data1_next;
   logic          note_valid_next, note_on_next;
   logic [6:0]    note_next, velocity_next;
   logic [3:0]    channel_next;
   logic          channel_match;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pstate       <= WAIT_STATUS;
         status       <= '0;
         status_valid <= 1'b0;
         data1        <= '0;
         note_valid   <= 1'b0;
         note_on      <= 1'b0;
         note         <= '0;
         velocity     <= '0;
         channel      <= '0;
      end else begin
         pstate       <= pstate_next;
         status       <= status_next;
         status_valid <= status_valid_next;
         data1        <= data1_next;
         note_valid   <= note_valid_next;
         note_on      <= note_on_next;
         note         <= note_next;
         velocity     <= velocity_next;
         channel      <= channel_next;
      end
   end

   assign channel_match = OMNI || (status[3:0] == MIDI_CHANNEL);

   always_comb begin
      pstate_next       = pstate;
      status_next       = status;
      status_valid_next = status_valid;
      data1_next        = data1;
      note_valid_next   = 1'b0;
      note_on_next      = note_on;
      note_next         = note;
      velocity_next     = velocity;
      channel_next      = channel;

      if (rx_framing_error) begin
         pstate_next       = WAIT_STATUS;
         status_valid_next = 1'b0;
      end else if (byte_valid) begin
         if (rx_byte >= REALTIME_MIN) begin
            // Real-time bytes may interleave anywhere and leave the parser untouched.
            pstate_next = pstate;
         end else if (rx_byte[7]) begin
            if (is_note_status(rx_byte)) begin
               status_next       = rx_byte;
               status_valid_next = 1'b1;
               pstate_next       = WAIT_DATA1;
            end else begin
               status_valid_next = 1'b0;
               pstate_next       = WAIT_STATUS;
            end
         end else begin
            case (pstate)
               WAIT_STATUS: begin
                  if (status_valid) begin
                     data1_next  = rx_byte[6:0];
                     pstate_next = WAIT_DATA2;
                  end
               end

               WAIT_DATA1: begin
                  data1_next  = rx_byte[6:0];
                  pstate_next = WAIT_DATA2;
               end

               WAIT_DATA2: begin
                  pstate_next = WAIT_DATA1;
                  if (channel_match) begin
                     note_valid_next = 1'b1;
                     note_next       = data1;
                     velocity_next   = rx_byte[6:0];
                     channel_next    = status[3:0];
                     note_on_next    = (status[7:4] == NOTE_ON) && (rx_byte[6:0] != 7'd0);
                  end
               end

               default: pstate_next = WAIT_STATUS;
            endcase
         end
      end
   end

   assign framing_error = rx_framing_error;

endmodule

// File: tb/tb_midi_note_receiver.sv
// Directed bench: serial MIDI stimulus, scoreboarded note events on a
// channel-0 receiver and an omni receiver sharing the same rx line.
module tb_midi_note_receiver;
   import midi_pkg::*;

   localparam int CLK_FREQ = 1_000_000;
   localparam int BIT      = CLK_FREQ / MIDI_BAUD;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic rx    = 1'b1;

   logic       note_valid, note_on, framing_error;
   logic [6:0] note, velocity;
   logic [3:0] channel;
   logic       o_note_valid, o_note_on, o_framing_error;
   logic [6:0] o_note, o_velocity;
   logic [3:0] o_channel;

   midi_note_receiver #(
      .CLK_FREQ (CLK_FREQ), .BAUD (MIDI_BAUD), .MIDI_CHANNEL (4'd0), .OMNI (1'b0)
   ) dut (
      .clk (clk), .reset (reset), .rx (rx), .note_valid (note_valid), .note_on (note_on),
      .note (note), .velocity (velocity), .channel (channel), .framing_error (framing_error)
   );

   midi_note_receiver #(
      .CLK_FREQ (CLK_FREQ), .BAUD (MIDI_BAUD), .MIDI_CHANNEL (4'd0), .OMNI (1'b1)
   ) dut_omni (
      .clk (clk), .reset (reset), .rx (rx), .note_valid (o_note_valid), .note_on (o_note_on),
      .note (o_note), .velocity (o_velocity), .channel (o_channel),
      .framing_error (o_framing_error)
   );

   always #5 clk = ~clk;

   int checks     = 0;
   int failures   = 0;
   int cyc        = 0;
   int last_bv    = -100;
   int o_last_bv  = -100;
   int bv_count   = 0;
   int ferr_count = 0;

   note_event_t exp_q[$];
   note_event_t omni_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic note_event_t make_ev(input logic [7:0] st, input logic [6:0] d1,
                                           input logic [6:0] d2);
      note_event_t e;
      e.note_on  = (st[7:4] == 4'h9) && (d2 != 7'd0);
      e.note     = d1;
      e.velocity = d2;
      e.channel  = st[3:0];
      return e;
   endfunction

   always @(posedge clk) cyc++;

   always @(negedge clk) begin : mon_main
      note_event_t e;
      if (dut.u_uart.byte_valid) begin
         last_bv = cyc;
         bv_count++;
      end
      if (framing_error) ferr_count++;
      if (note_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_note", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("note_on",  note_on,  e.note_on);
            check("note",     note,     e.note);
            check("velocity", velocity, e.velocity);
            check("channel",  channel,  e.channel);
            check("latency",  cyc - last_bv, 1);
         end
      end
   end

   always @(negedge clk) begin : mon_omni
      note_event_t e;
      if (dut_omni.u_uart.byte_valid) o_last_bv = cyc;
      if (o_note_valid) begin
         if (omni_q.size() == 0) begin
            check("omni_unexpected_note", 1, 0);
         end else begin
            e = omni_q.pop_front();
            check("omni_note_on",  o_note_on,  e.note_on);
            check("omni_note",     o_note,     e.note);
            check("omni_velocity", o_velocity, e.velocity);
            check("omni_channel",  o_channel,  e.channel);
            check("omni_latency",  cyc - o_last_bv, 1);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
      @(posedge clk); #1 rx = 1'b0;
      repeat (BIT) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         #1 rx = b[i];
         repeat (BIT) @(posedge clk);
      end
      #1 rx = stop_bit;
      repeat (BIT) @(posedge clk);
      #1 rx = 1'b1;
      repeat (BIT) @(posedge clk);
   endtask

   task automatic check_outputs_zero(input string tag);
      @(negedge clk);
      check({tag, "_note_valid"},    note_valid,    0);
      check({tag, "_note_on"},       note_on,       0);
      check({tag, "_note"},          note,          0);
      check({tag, "_velocity"},      velocity,      0);
      check({tag, "_channel"},       channel,       0);
      check({tag, "_framing_error"}, framing_error, 0);
   endtask

   initial begin
      int bv_before;
      logic [7:0] partial;

      repeat (5) @(posedge clk);
      #1 reset = 1'b0;
      check_outputs_zero("reset");

      // Plain note-on, then running status with velocity 0 (reported as note-off).
      exp_q.push_back(make_ev(8'h90, 7'h3C, 7'h64));
      omni_q.push_back(make_ev(8'h90, 7'h3C, 7'h64));
      send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
      exp_q.push_back(make_ev(8'h90, 7'h3E, 7'h00));
      omni_q.push_back(make_ev(8'h90, 7'h3E, 7'h00));
      send_byte(8'h3E); send_byte(8'h00);

      // Real-time bytes interleaved mid-message.
      exp_q.push_back(make_ev(8'h90, 7'h40, 7'h7F));
      omni_q.push_back(make_ev(8'h90, 7'h40, 7'h7F));
      send_byte(8'h90); send_byte(8'hF8); send_byte(8'h40); send_byte(8'hFE); send_byte(8'h7F);

      // Channel 3 note-off: omni receiver only.
      omni_q.push_back(make_ev(8'h83, 7'h40, 7'h00));
      send_byte(8'h83); send_byte(8'h40); send_byte(8'h00);
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("hold_note",          note,       7'h40);
      check("hold_velocity",      velocity,   7'h7F);
      check("hold_note_on",       note_on,    1);
      check("hold_channel",       channel,    0);
      check("omni_hold_channel",  o_channel,  3);
      check("omni_hold_velocity", o_velocity, 0);

      // Status byte with a low stop bit clears running status.
      send_byte(8'h90, 1'b0); send_byte(8'h3C); send_byte(8'h64);
      check("framing_error_count", ferr_count, 1);

      // Low glitch shorter than half a bit.
      bv_before = bv_count;
      @(posedge clk); #1 rx = 1'b0;
      repeat (5) @(posedge clk);
      #1 rx = 1'b1;
      repeat (3 * BIT) @(posedge clk);
      check("glitch_no_byte", bv_count, bv_before);
      check("glitch_no_ferr", ferr_count, 1);

      // Reset during data bit 4 of the third byte aborts the message.
      send_byte(8'h90); send_byte(8'h3C);
      partial = 8'h64;
      @(posedge clk); #1 rx = 1'b0;
      repeat (BIT) @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         #1 rx = partial[i];
         repeat ((i == 4) ? BIT / 2 : BIT) @(posedge clk);
      end
      #1 reset = 1'b1;
      rx = 1'b1;
      repeat (4) @(posedge clk);
      check_outputs_zero("midreset");
      @(posedge clk); #1 reset = 1'b0;
      repeat (3 * BIT) @(posedge clk);
      check("midreset_no_pulse_q", exp_q.size(), 0);

      exp_q.push_back(make_ev(8'h80, 7'h3C, 7'h40));
      omni_q.push_back(make_ev(8'h80, 7'h3C, 7'h40));
      send_byte(8'h80); send_byte(8'h3C); send_byte(8'h40);

      repeat (2 * BIT) @(posedge clk);
      check("exp_q_drained",  exp_q.size(),  0);
      check("omni_q_drained", omni_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
